// File: rtl/seq_alu.sv
// Registered ALU with optional iterative multiply/divide (enable with SEQ_ALU_MULDIV_EN).
// Single-cycle ops complete at acceptance; MUL/DIVU/REMU take WIDTH iteration cycles.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic             accept;
    logic             is_multi;
    logic             done;
    logic [WIDTH-1:0] md_res;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;

    assign accept = in_valid && in_ready;
    assign shamt  = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SUB:  alu_res = a - b;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            default: alu_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc, acc_n;   // MUL: partial product; DIV: partial remainder
    logic [WIDTH-1:0] x, x_n;       // MUL: multiplier; DIV: dividend shifting into quotient
    logic [WIDTH-1:0] y, y_n;       // MUL: shifted multiplicand; DIV: divisor
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic             kind_mul, kind_rem;

    assign is_multi = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    assign in_ready = (state == IDLE);
    assign done     = (state == BUSY) && (cnt == (SHW+1)'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_multi) state_next = BUSY;
            BUSY:    if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divide by zero falls out naturally: every step subtracts 0, giving all-ones quotient and remainder a.
    always_comb begin
        rem_sh = {acc, x[WIDTH-1]};
        ge     = rem_sh >= {1'b0, y};
        if (kind_mul) begin
            acc_n = acc + (x[0] ? y : '0);
            x_n   = x >> 1;
            y_n   = y << 1;
        end else begin
            acc_n = ge ? WIDTH'(rem_sh - {1'b0, y}) : WIDTH'(rem_sh);
            x_n   = {x[WIDTH-2:0], ge};
            y_n   = y;
        end
        md_res = (kind_mul || kind_rem) ? acc_n : x_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            x        <= '0;
            y        <= '0;
            kind_mul <= 1'b0;
            kind_rem <= 1'b0;
        end else if (state == IDLE) begin
            if (accept && is_multi) begin
                cnt      <= (SHW+1)'(WIDTH);
                acc      <= '0;
                kind_mul <= (op == OP_MUL);
                kind_rem <= (op == OP_REMU);
                x        <= (op == OP_MUL) ? b : a;
                y        <= (op == OP_MUL) ? a : b;
            end
        end else begin
            cnt <= cnt - 1'b1;
            acc <= acc_n;
            x   <= x_n;
            y   <= y_n;
        end
    end
`else
    assign is_multi = 1'b0;
    assign in_ready = 1'b1;
    assign done     = 1'b0;
    assign md_res   = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_multi) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
            end else if (done) begin
                out_valid <= 1'b1;
                result    <= md_res;
                zero      <= (md_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); multi-cycle checks follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for the accepting edge, sample 1ns later.
    task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        #1;
    endtask

`ifdef SEQ_ALU_MULDIV_EN
    task automatic mdrun(input string tag, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
        int n;
        drive(o, x, y);
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, 32);
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_res"}, result, exp);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        @(negedge clk);
        rst = 1'b0;

        drive(4'b0010, 32'hFFFF_FFFF, 32'h1);
        chk("add_ov", out_valid, 1);
        chk("add_res", result, 32'h0);
        chk("add_zero", zero, 1);
        chk("add_ready", in_ready, 1);
        drive(4'b0110, 32'd5, 32'd7);
        chk("sub_ov", out_valid, 1);
        chk("sub_res", result, 32'hFFFF_FFFE);
        chk("sub_zero", zero, 0);
        drive(4'b0111, 32'h8000_0000, 32'h21);
        chk("sra_neg", result, 32'hC000_0000);
        drive(4'b1000, 32'hFFFF_FFFF, 32'h1);
        chk("slt_res", result, 32'h1);
        chk("slt_zero", zero, 0);
        drive(4'b1001, 32'hFFFF_FFFF, 32'h1);
        chk("sltu_res", result, 32'h0);
        chk("sltu_zero", zero, 1);
        drive(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        chk("and_res", result, 32'h00F0_1234);
        drive(4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F);
        chk("xor_res", result, 32'hF0F0_0F0F);
        drive(4'b0100, 32'h1, 32'hFFFF_FF3F);
        chk("sll_res", result, 32'h8000_0000);
        drive(4'b0101, 32'h8000_0000, 32'h4);
        chk("srl_res", result, 32'h0800_0000);
        drive(4'b0111, 32'h4000_0000, 32'h2);
        chk("sra_pos", result, 32'h1000_0000);
        drive(4'b1111, 32'h1234, 32'h5678);
        chk("undef_res", result, 32'h0);
        chk("undef_zero", zero, 1);
        drive(4'b0001, 32'hF000_0000, 32'h0000_000F);
        chk("or_res", result, 32'hF000_000F);
        chk("or_ov", out_valid, 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ov", out_valid, 0);
        chk("idle_hold", result, 32'hF000_000F);
        chk("idle_zero", zero, 0);

        drive(4'b0011, 32'h0000_00FF, 32'h0000_0F00);
        chk("xor2_res", result, 32'h0000_0FFF);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_res", result, 0);
        chk("arst_zero", zero, 0);
        chk("arst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

`ifndef SEQ_ALU_MULDIV_EN
        drive(4'b0010, 32'd20, 32'd22);
        chk("pre_mul_res", result, 32'd42);
        drive(4'b1010, 32'd3, 32'd4);
        chk("nomul_ov", out_valid, 1);
        chk("nomul_res", result, 32'h0);
        chk("nomul_zero", zero, 1);
        chk("nomul_ready", in_ready, 1);
        drive(4'b0010, 32'd1, 32'd1);
        chk("pre_div_res", result, 32'd2);
        drive(4'b1011, 32'd100, 32'd7);
        chk("nodiv_res", result, 32'h0);
        chk("nodiv_ready", in_ready, 1);
        in_valid = 1'b0;
        begin
            int drops = 0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                if (!in_ready) drops++;
            end
            chk("nomul_ready_hold", drops, 0);
        end
`else
        begin
            int n, low;
            drive(4'b1010, 32'h0001_0003, 32'h0000_0005);
            chk("mul_busy_ready", in_ready, 0);
            chk("mul_busy_ov", out_valid, 0);
            op = 4'b0010; a = 32'd2; b = 32'd3;
            n = 0;
            low = 1;
            for (int i = 0; i < 40 && !out_valid; i++) begin
                @(posedge clk);
                #1;
                n++;
                if (!in_ready) low++;
            end
            chk("mul_lat", n, 32);
            chk("mul_low", low, 32);
            chk("mul_res", result, 32'h0005_000F);
            chk("mul_ready_back", in_ready, 1);
            @(posedge clk);
            #1;
            chk("held_ov", out_valid, 1);
            chk("held_res", result, 32'd5);
            in_valid = 1'b0;
        end
        mdrun("divu", 4'b1011, 32'd100, 32'd7, 32'd14);
        mdrun("remu", 4'b1100, 32'd100, 32'd7, 32'd2);
        mdrun("divu0", 4'b1011, 32'd9, 32'd0, 32'hFFFF_FFFF);
        mdrun("remu0", 4'b1100, 32'd9, 32'd0, 32'd9);
        begin
            int pulses = 0;
            drive(4'b1011, 32'd100, 32'd7);
            in_valid = 1'b0;
            repeat (9) @(posedge clk);
            #3;
            rst = 1'b1;
            #1;
            chk("abort_ready", in_ready, 1);
            chk("abort_ov", out_valid, 0);
            chk("abort_res", result, 0);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            chk("abort_ready_after", in_ready, 1);
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) pulses++;
            end
            chk("abort_no_ov", pulses, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
